dpram_128x8_fifo_ctrl: RTL and testbench
========================================

// Module: dpram_128x8_fifo_ctrl
// PURPOSE
//  Synchronous FIFO controller feeding dpram_128x8 (unified-clock 128x8 dual-port RAM).
//  Converts a valid/ready input stream into RAM write strobes/addresses.
//  Issues RAM reads and presents RAM data_out as a show-ahead valid/ready output stream.
//  Sits directly upstream of the RAM macro in the mem1K fabric wrapper; one instance per RAM.
// PARAMETERS
//  ADDR_WIDTH    7    RAM address width; storage depth = 2**ADDR_WIDTH = 128
//  DATA_WIDTH    8    word width; equals RAM data width
//  AFULL_THRESH  120  level at or above which afull asserts (DPRAM_FIFO_LEVEL_EN only)
// PORTS
//  clk           in   1           single clock; also drives RAM clk
//  rst_n         in   1           asynchronous active-low reset
//  in_valid      in   1           upstream word valid
//  in_ready      out  1           FIFO can accept; = (ram_level != 128)
//  in_data       in   DATA_WIDTH  upstream word
//  out_valid     out  1           out_data holds the head word
//  out_ready     in   1           downstream consumes head when out_valid & out_ready
//  out_data      out  DATA_WIDTH  head word; wired straight from ram_data_out
//  ram_wen       out  1           to RAM wen
//  ram_waddr     out  ADDR_WIDTH  to RAM waddr (= wptr[6:0])
//  ram_data_in   out  DATA_WIDTH  to RAM data_in (= in_data)
//  ram_ren       out  1           to RAM ren
//  ram_raddr     out  ADDR_WIDTH  to RAM raddr (= rptr[6:0])
//  ram_data_out  in   DATA_WIDTH  from RAM data_out (registered inside RAM, holds when ren=0)
// BEHAVIOUR
//  - wptr, rptr: ADDR_WIDTH+1 bits, wrap mod 256; ram_level = wptr - rptr (0..128)
//  - push = in_valid & in_ready; ram_wen = push (combinational); wptr++ on push
//  - pop  = out_valid & out_ready
//  - ram_ren = (ram_level != 0) & (!out_valid | pop); rptr++ on ram_ren
//  - Output stage is the RAM's read register. Two states:
//      EMPTY: out_valid=0; -> FULL when ram_ren
//      FULL : out_valid=1; stays FULL on pop&ram_ren (back-to-back), -> EMPTY on pop&!ram_ren
//  - Hold: out_valid & !out_ready -> no read, RAM holds out_data stable
//  - Latency: push at edge N -> RAM write at N, read at N+1, out_valid=1 after N+1
//  - Throughput: 1 push + 1 pop per cycle sustained
//  - Total capacity 129 words (128 RAM + 1 output register); in_ready depends only on ram_level
//  - Full (ram_level=128): in_ready=0, ram_wen=0; no write to the unread slot
//  - Empty (ram_level=0): ram_ren=0; push on the same cycle is not readable until next cycle
//  - Simultaneous push & read at full-level-1 etc.: pointers update independently; level += push - ram_ren
//  - No RAM address collision: read addr always < write addr in FIFO order; same-address
//    write/read in one cycle is impossible by construction (full blocks write, empty blocks read)
//  - Reset (any time, mid-stream included): wptr=rptr=0, out_valid=0, in_ready=1,
//    ram_wen=0, ram_ren=0; RAM contents not cleared; ram_data_out stale and ignored
//  - Reset deassertion is synchronised externally; block only requires async assert
// CONFIGURATION
//  DPRAM_FIFO_LEVEL_EN defined:
//    extra ports level out ADDR_WIDTH+2 (= ram_level + out_valid, 0..129), afull out 1
//    afull registered: 1 when next level >= AFULL_THRESH; reset: level=0, afull=0
//  DPRAM_FIFO_LEVEL_EN undefined: ports level/afull absent; no extra logic
// TESTING
//  1 reset, push 0xA5 once, out_ready=1 -> out_valid rises 2 edges after push, out_data=0xA5, pops
//  2 push 0x00..0x80 (129 words), out_ready=0 -> in_ready=0 after 129th; ram_level=128, out_data=0x00
//  3 from 2, pop continuously -> 0x00..0x80 in order, one per cycle, in_ready=1 after first read
//  4 stream 1000 words, in_valid & out_ready random 50% -> output == input order, no loss/dup
//  5 wraparound: 300 words push/pop interleaved -> pointers wrap past 256, data correct
//  6 rst_n low mid-stream with level=40 -> out_valid=0, in_ready=1 immediately; post-reset
//    push 0x3C -> first word out is 0x3C; with DPRAM_FIFO_LEVEL_EN: level 0, afull at 120

Source files
------------

// File: rtl/dpram_128x8_fifo_ctrl.sv
// Synchronous FIFO controller for a 128x8 dual-port RAM. The RAM's read register is the show-ahead output stage.
// Optional level/afull outputs are enabled by defining DPRAM_FIFO_LEVEL_EN.
module dpram_128x8_fifo_ctrl #(
  parameter int ADDR_WIDTH   = 7,
  parameter int DATA_WIDTH   = 8,
  parameter int AFULL_THRESH = 120
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  ram_wen,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  output logic                  ram_ren,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  input  logic [DATA_WIDTH-1:0] ram_data_out
`ifdef DPRAM_FIFO_LEVEL_EN
  ,
  output logic [ADDR_WIDTH+1:0] level,
  output logic                  afull
`endif
);

  // Both streams use valid/ready: a word transfers on a rising clk edge where valid and ready
  // are both high; valid never depends on ready, and ready never depends on valid.

  localparam logic [ADDR_WIDTH:0] FULL_LEVEL = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   wptr_q, wptr_d;
  logic [ADDR_WIDTH:0]   rptr_q, rptr_d;
  logic [ADDR_WIDTH:0]   ram_level;
  logic                  push;
  logic                  pop;

  // Level counts only words still held in the RAM, so the output register adds one more slot.
  assign ram_level   = wptr_q - rptr_q;
  assign in_ready    = (ram_level != FULL_LEVEL);
  // Writes are gated by rst_n so an in-flight word cannot reach the RAM during reset.
  assign push        = in_valid & in_ready & rst_n;
  assign ram_wen     = push;
  assign ram_waddr   = wptr_q[ADDR_WIDTH-1:0];
  assign ram_raddr   = rptr_q[ADDR_WIDTH-1:0];
  assign ram_data_in = in_data;
  assign out_data    = ram_data_out;

  always_comb begin
    state_d   = state_q;
    out_valid = 1'b0;
    pop       = 1'b0;
    ram_ren   = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        ram_ren = (ram_level != '0);
        if (ram_ren) state_d = ST_FULL;
      end
      ST_FULL: begin
        out_valid = 1'b1;
        pop       = out_ready;
        // While the head is held, no read is issued so the RAM keeps out_data stable.
        ram_ren   = pop & (ram_level != '0);
        if (pop && !ram_ren) state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  assign wptr_d = wptr_q + {{ADDR_WIDTH{1'b0}}, push};
  assign rptr_d = rptr_q + {{ADDR_WIDTH{1'b0}}, ram_ren};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
    end
  end

`ifdef DPRAM_FIFO_LEVEL_EN
  localparam logic [ADDR_WIDTH+1:0] AFULL_LVL = (ADDR_WIDTH+2)'(AFULL_THRESH);

  logic [ADDR_WIDTH:0]   ram_level_d;
  logic [ADDR_WIDTH+1:0] level_d;
  logic                  afull_q;

  assign ram_level_d = wptr_d - rptr_d;
  assign level_d     = {1'b0, ram_level_d} + {{(ADDR_WIDTH+1){1'b0}}, (state_d == ST_FULL)};
  assign level       = {1'b0, ram_level} + {{(ADDR_WIDTH+1){1'b0}}, out_valid};
  assign afull       = afull_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) afull_q <= 1'b0;
    else        afull_q <= (level_d >= AFULL_LVL);
  end
`endif

endmodule

// File: tb/tb_dpram_128x8_fifo_ctrl.sv
// Directed bench for dpram_128x8_fifo_ctrl with a behavioural 128x8 RAM attached.
// Build with DPRAM_FIFO_LEVEL_EN defined to also cover level/afull.
module tb_dpram_128x8_fifo_ctrl;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       ram_wen;
  logic [6:0] ram_waddr;
  logic [7:0] ram_data_in;
  logic       ram_ren;
  logic [6:0] ram_raddr;
  logic [7:0] ram_data_out;
`ifdef DPRAM_FIFO_LEVEL_EN
  logic [8:0] level;
  logic       afull;
`endif

  int checks = 0;
  int errors = 0;
  int wptr_m = 0;
  int rptr_m = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mem[128];

  dpram_128x8_fifo_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .ram_wen      (ram_wen),
    .ram_waddr    (ram_waddr),
    .ram_data_in  (ram_data_in),
    .ram_ren      (ram_ren),
    .ram_raddr    (ram_raddr),
    .ram_data_out (ram_data_out)
`ifdef DPRAM_FIFO_LEVEL_EN
    ,
    .level        (level),
    .afull        (afull)
`endif
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM model: registered read that holds when ren is low
  always @(posedge clk) begin
    if (ram_wen) mem[ram_waddr] <= ram_data_in;
    if (ram_ren) ram_data_out <= mem[ram_raddr];
  end

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b exp 1", in_ready); end
    checks++; if (ram_wen !== 1'b0) begin errors++; $display("FAIL reset_ram_wen got %0b exp 0", ram_wen); end
    checks++; if (ram_ren !== 1'b0) begin errors++; $display("FAIL reset_ram_ren got %0b exp 0", ram_ren); end
    checks++; if (ram_waddr !== 7'd0) begin errors++; $display("FAIL reset_waddr got %0d exp 0", ram_waddr); end
    checks++; if (ram_raddr !== 7'd0) begin errors++; $display("FAIL reset_raddr got %0d exp 0", ram_raddr); end
`ifdef DPRAM_FIFO_LEVEL_EN
    checks++; if (level !== 9'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
    checks++; if (afull !== 1'b0) begin errors++; $display("FAIL reset_afull got %0b exp 0", afull); end
`endif
    rst_n = 1'b1;
    @(negedge clk);
    wptr_m = 0; rptr_m = 0;
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
    #1;
    checks++; if (ram_wen !== 1'b1) begin errors++; $display("FAIL single_wen got %0b exp 1", ram_wen); end
    checks++; if (ram_waddr !== 7'(wptr_m)) begin errors++; $display("FAIL single_waddr got %0d exp %0d", ram_waddr, wptr_m % 128); end
    checks++; if (ram_data_in !== 8'hA5) begin errors++; $display("FAIL single_data_in got %h exp a5", ram_data_in); end
    @(negedge clk);
    in_valid = 1'b0; wptr_m++;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_valid_early got %0b exp 0", out_valid); end
    checks++; if (ram_ren !== 1'b1) begin errors++; $display("FAIL single_ren got %0b exp 1", ram_ren); end
    checks++; if (ram_raddr !== 7'(rptr_m)) begin errors++; $display("FAIL single_raddr got %0d exp %0d", ram_raddr, rptr_m % 128); end
    @(negedge clk);
    rptr_m++;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %0b exp 1", out_valid); end
    checks++; if (out_data !== 8'hA5) begin errors++; $display("FAIL single_data got %h exp a5", out_data); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_popped got %0b exp 0", out_valid); end
    checks++; if (ram_ren !== 1'b0) begin errors++; $display("FAIL single_ren_idle got %0b exp 0", ram_ren); end
    out_ready = 1'b0;
  endtask

  task automatic test_fill();
    out_ready = 1'b0;
    for (int i = 0; i < 129; i++) begin
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_in_ready[%0d] got %0b exp 1", i, in_ready); end
`ifdef DPRAM_FIFO_LEVEL_EN
      checks++; if (level !== 9'(i)) begin errors++; $display("FAIL fill_level[%0d] got %0d exp %0d", i, level, i); end
      checks++; if (afull !== (i >= 120)) begin errors++; $display("FAIL fill_afull[%0d] got %0b exp %0b", i, afull, i >= 120); end
`endif
      in_valid = 1'b1; in_data = 8'(i);
      @(negedge clk);
    end
    wptr_m += 129; rptr_m += 1;
    in_data = 8'h81;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %0b exp 0", in_ready); end
    checks++; if (ram_wen !== 1'b0) begin errors++; $display("FAIL full_wen got %0b exp 0", ram_wen); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL full_out_valid got %0b exp 1", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL full_out_data got %h exp 00", out_data); end
    checks++; if (ram_ren !== 1'b0) begin errors++; $display("FAIL full_hold_ren got %0b exp 0", ram_ren); end
`ifdef DPRAM_FIFO_LEVEL_EN
    checks++; if (level !== 9'd129) begin errors++; $display("FAIL full_level got %0d exp 129", level); end
    checks++; if (afull !== 1'b1) begin errors++; $display("FAIL full_afull got %0b exp 1", afull); end
`endif
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL full_hold_data got %h exp 00", out_data); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_hold_ready got %0b exp 0", in_ready); end
  endtask

  task automatic test_drain();
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 129; i++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL drain_valid[%0d] got %0b exp 1", i, out_valid); end
      checks++; if (out_data !== 8'(i)) begin errors++; $display("FAIL drain_data[%0d] got %h exp %h", i, out_data, 8'(i)); end
      checks++; if (in_ready !== (i > 0)) begin errors++; $display("FAIL drain_in_ready[%0d] got %0b exp %0b", i, in_ready, i > 0); end
      @(negedge clk);
    end
    rptr_m += 128;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got %0b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL drain_ready got %0b exp 1", in_ready); end
    out_ready = 1'b0;
  endtask

  // Scoreboarded stream: pushed words enter exp_q, every pop is compared in order.
  task automatic test_stream(input int n, input int in_pct, input int out_pct, input string name);
    int sent = 0;
    int got = 0;
    int cyc = 0;
    logic [7:0] exp;
    exp_q.delete();
    while (got < n && cyc < 40 * n) begin
      in_valid  = (sent < n) && ($urandom_range(99) < in_pct);
      in_data   = 8'(sent * 37 + 11);
      out_ready = ($urandom_range(99) < out_pct);
      #1;
      if (in_valid && in_ready) begin
        checks++; if (ram_waddr !== 7'(wptr_m)) begin errors++; $display("FAIL %s_waddr got %0d exp %0d", name, ram_waddr, wptr_m % 128); end
        exp_q.push_back(in_data);
        sent++; wptr_m++;
      end
      if (ram_ren) begin
        checks++; if (ram_raddr !== 7'(rptr_m)) begin errors++; $display("FAIL %s_raddr got %0d exp %0d", name, ram_raddr, rptr_m % 128); end
        rptr_m++;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL %s_dup got %h exp none", name, out_data);
        end else begin
          exp = exp_q.pop_front();
          if (out_data !== exp) begin errors++; $display("FAIL %s_data[%0d] got %h exp %h", name, got, out_data, exp); end
        end
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (got != n) begin errors++; $display("FAIL %s_count got %0d exp %0d", name, got, n); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL %s_left got %0d exp 0", name, exp_q.size()); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_extra got %0b exp 0", name, out_valid); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < 41; i++) begin
      in_valid = 1'b1; in_data = 8'(i + 100);
      @(negedge clk);
    end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got %0b exp 1", out_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid got %0b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready got %0b exp 1", in_ready); end
    checks++; if (ram_wen !== 1'b0) begin errors++; $display("FAIL mid_wen got %0b exp 0", ram_wen); end
    checks++; if (ram_ren !== 1'b0) begin errors++; $display("FAIL mid_ren got %0b exp 0", ram_ren); end
    checks++; if (ram_waddr !== 7'd0) begin errors++; $display("FAIL mid_waddr got %0d exp 0", ram_waddr); end
`ifdef DPRAM_FIFO_LEVEL_EN
    checks++; if (level !== 9'd0) begin errors++; $display("FAIL mid_level got %0d exp 0", level); end
    checks++; if (afull !== 1'b0) begin errors++; $display("FAIL mid_afull got %0b exp 0", afull); end
`endif
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b1; in_data = 8'h3C; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_post_valid got %0b exp 1", out_valid); end
    checks++; if (out_data !== 8'h3C) begin errors++; $display("FAIL mid_post_data got %h exp 3c", out_data); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_post_empty got %0b exp 0", out_valid); end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_drain();
    test_stream(1000, 50, 50, "random");
    test_stream(300, 100, 100, "wrap");
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
